// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: decides per cycle which pipeline
// registers load, hold or take a bubble, picks the next-PC source, and counts stalls/flushes.
module pipeline_hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int EXC_DRAIN = 2,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  input  logic             exc_req,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             ex_mem_flush,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_EXC_DRAIN = 2'd2
  } state_t;

  localparam int DW = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;

  state_t        state, state_nx;
  logic [DW-1:0] drain_cnt, drain_nx;
  logic          load_use;
  logic          exc_take;
  logic          any_flush;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  // Exceptions stay masked while the previous redirect drains.
  assign exc_take = exc_req && (state != ST_EXC_DRAIN);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_nx;
    end
  end

  always_comb begin
    state_nx = state;
    drain_nx = drain_cnt;
    if (exc_take) begin
      state_nx = ST_EXC_DRAIN;
      drain_nx = DW'(EXC_DRAIN - 1);
    end else if (state == ST_EXC_DRAIN) begin
      // Memory wait stretches the drain window instead of leaving it.
      if (!mem_busy) begin
        if (drain_cnt == '0) state_nx = ST_RUN;
        else                 drain_nx = drain_cnt - DW'(1);
      end
    end else if (mem_busy) begin
      state_nx = ST_MEM_WAIT;
    end else begin
      state_nx = ST_RUN;
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    ex_mem_flush = 1'b0;
    pc_sel       = 2'b00;
    if (reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if (exc_take) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        pc_sel       = 2'b11;
      end else if (mem_busy) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
      end else if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        pc_sel      = 2'b01;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
        pc_sel      = 2'b10;
      end
    end
  end

  assign any_flush = if_id_flush || id_ex_flush || ex_mem_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with 3-bit counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  // Control vector: pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
  // ex_mem_write, ex_mem_flush, pc_sel[1:0]
  localparam logic [8:0] C_DEF = 9'b110101000;
  localparam logic [8:0] C_STL = 9'b000000000;
  localparam logic [8:0] C_LU  = 9'b000111000;
  localparam logic [8:0] C_BR  = 9'b111111001;
  localparam logic [8:0] C_JMP = 9'b111101010;
  localparam logic [8:0] C_EXC = 9'b111111111;
  localparam logic [8:0] C_RST = 9'b000000000;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MEM = 2'd1;
  localparam logic [1:0] S_DRN = 2'd2;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_use_rs, id_use_rt, ex_mem_read, ex_br_taken, id_jump;
  logic             mem_busy, exc_req, cnt_clr;
  logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic             ex_mem_write, ex_mem_flush;
  logic [1:0]       pc_sel, state_dbg;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [16:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .EXC_DRAIN(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
    .id_jump(id_jump), .mem_busy(mem_busy), .exc_req(exc_req), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush), .pc_sel(pc_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs       = '0;
    id_rt       = '0;
    ex_rd       = '0;
    id_use_rs   = 1'b0;
    id_use_rt   = 1'b0;
    ex_mem_read = 1'b0;
    ex_br_taken = 1'b0;
    id_jump     = 1'b0;
    mem_busy    = 1'b0;
    exc_req     = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  // Inputs change on the falling edge, well away from the active edge.
  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic set_load_use(input logic [REG_W-1:0] rd);
    ex_mem_read = 1'b1;
    ex_rd       = rd;
    id_rs       = 5'd8;
    id_use_rs   = 1'b1;
  endtask

  // Scoreboard: push the expectation for this cycle, then pop and compare 1 time unit later.
  task automatic check(input string tag, input logic [8:0] ctrl, input logic [1:0] st,
                       input int sc, input int fc);
    logic [16:0] obs;
    logic [16:0] exp_v;
    exp_q.push_back({ctrl, st, CNT_W'(sc), CNT_W'(fc)});
    #1;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, ex_mem_flush, pc_sel, state_dbg, stall_cnt, flush_cnt};
    exp_v = exp_q.pop_front();
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  initial begin
    idle();
    reset   = 1'b0;
    exc_req = 1'b1;
    #12;
    check("reset_hold", C_RST, S_RUN, 0, 0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    next(); check("idle", C_DEF, S_RUN, 0, 0);
    next(); set_load_use(5'd8); check("load_use_rs", C_LU, S_RUN, 0, 0);
    next(); set_load_use(5'd0); check("load_use_r0", C_DEF, S_RUN, 1, 1);
    next(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
            id_rs = 5'd3; id_use_rs = 1'b1;
            check("load_use_rt", C_LU, S_RUN, 1, 1);
    next(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_use_rs = 1'b1;
            check("rt_unused", C_DEF, S_RUN, 2, 2);
    next(); id_jump = 1'b1; check("jump", C_JMP, S_RUN, 2, 2);
    next(); set_load_use(5'd8); id_jump = 1'b1; check("lu_beats_jump", C_LU, S_RUN, 2, 3);
    next(); cnt_clr = 1'b1; check("clr_idle", C_DEF, S_RUN, 3, 4);
    next(); set_load_use(5'd8); id_jump = 1'b1; ex_br_taken = 1'b1;
            check("branch_wins", C_BR, S_RUN, 0, 0);
    next(); check("after_branch", C_DEF, S_RUN, 0, 1);

    next(); mem_busy = 1'b1; check("mem_wait_1", C_STL, S_RUN, 0, 1);
    next(); mem_busy = 1'b1; check("mem_wait_2", C_STL, S_MEM, 1, 1);
    next(); mem_busy = 1'b1; check("mem_wait_3", C_STL, S_MEM, 2, 1);
    next(); id_jump = 1'b1; check("mem_exit_jump", C_JMP, S_MEM, 3, 1);
    next(); check("back_in_run", C_DEF, S_RUN, 3, 2);

    next(); mem_busy = 1'b1; check("exc_pre_wait", C_STL, S_RUN, 3, 2);
    next(); mem_busy = 1'b1; exc_req = 1'b1; check("exc_in_wait", C_EXC, S_MEM, 4, 2);
    next(); exc_req = 1'b1; check("exc_masked_1", C_DEF, S_DRN, 4, 3);
    next(); exc_req = 1'b1; check("exc_masked_2", C_DEF, S_DRN, 4, 3);
    next(); exc_req = 1'b1; check("exc_taken", C_EXC, S_RUN, 4, 3);
    next(); check("drain_idle", C_DEF, S_DRN, 4, 4);

    #2 reset = 1'b0;
    check("async_reset", C_RST, S_RUN, 0, 0);
    repeat (2) @(posedge clk);
    next(); reset = 1'b1; exc_req = 1'b1; check("exc_after_reset", C_EXC, S_RUN, 0, 0);
    next(); mem_busy = 1'b1; check("drain_mem_busy", C_STL, S_DRN, 0, 1);
    next(); exc_req = 1'b1; check("drain_still_masked", C_DEF, S_DRN, 1, 1);
    next(); check("drain_last", C_DEF, S_DRN, 1, 1);
    next(); check("drain_done", C_DEF, S_RUN, 1, 1);

    next(); cnt_clr = 1'b1; check("clr_before_sat", C_DEF, S_RUN, 1, 1);
    for (int i = 0; i < 10; i++) begin
      next(); mem_busy = 1'b1;
      check("stall_sat", C_STL, (i == 0) ? S_RUN : S_MEM, (i > 7) ? 7 : i, 0);
    end
    next(); mem_busy = 1'b1; cnt_clr = 1'b1; check("clr_in_wait", C_STL, S_MEM, 7, 0);
    next(); mem_busy = 1'b1; check("cleared", C_STL, S_MEM, 0, 0);
    next(); check("wait_exit", C_DEF, S_MEM, 1, 0);
    next(); check("run_again", C_DEF, S_RUN, 1, 0);
    for (int i = 0; i < 9; i++) begin
      next(); id_jump = 1'b1;
      check("flush_sat", C_JMP, S_RUN, 1, (i > 7) ? 7 : i);
    end
    next(); check("flush_final", C_DEF, S_RUN, 1, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
